fix_blk_norm: RTL and testbench



---
 rtl/fix_pkg.sv | 24 ++
 rtl/fix_blk_norm_if.sv | 27 ++
 rtl/fix_sign_cnt.sv | 25 ++
 rtl/fix_blk_norm.sv | 130 +++++++++++++
 tb/tb_fix_blk_norm.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fix_pkg.sv
// Shared types and a reference headroom function for the block-floating-point normaliser.
package fix_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_SHIFT_W   = $clog2(DEF_WIDTH);

  typedef logic [DEF_SHIFT_W-1:0] shift_t;

  typedef enum logic {FILL, DRAIN} state_t;

  // Redundant sign bits: position of the highest bit that differs from the MSB.
  function automatic shift_t headroom(input logic [DEF_WIDTH-1:0] sample);
    logic [DEF_WIDTH-1:0] diff;
    shift_t               cnt;
    diff = sample ^ {DEF_WIDTH{sample[DEF_WIDTH-1]}};
    cnt  = shift_t'(DEF_WIDTH-1);
    for (int i = 0; i < DEF_WIDTH-1; i++) begin
      if (diff[i]) cnt = shift_t'(DEF_WIDTH-2-i);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fix_blk_norm_if.sv
// Sample stream in, normalised sample stream out, plus the frame exponent sideband.
interface fix_blk_norm_if import fix_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = $clog2(WIDTH)
) ();

  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [SHIFT_W-1:0] frame_exp;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_shift, out_valid, out_last, frame_exp
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_shift, out_valid, out_last, frame_exp
  );

endinterface

// File: rtl/fix_sign_cnt.sv
// Combinational redundant-sign-bit counter: bits below the MSB that still match it.
module fix_sign_cnt import fix_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_data,
  output logic [SHIFT_W-1:0] o_cnt
);

  logic               w_run;
  logic [SHIFT_W-1:0] w_cnt;

  // Walk down from just below the MSB and stop counting at the first differing bit.
  always_comb begin
    w_cnt = '0;
    w_run = 1'b1;
    for (int i = WIDTH-2; i >= 0; i--) begin
      if (w_run && (i_data[i] == i_data[WIDTH-1])) w_cnt = w_cnt + SHIFT_W'(1);
      else                                          w_run = 1'b0;
    end
  end

  assign o_cnt = w_cnt;

endmodule

// File: rtl/fix_blk_norm.sv
// Buffers one frame, finds its common headroom, then replays the frame with that shift amount.
module fix_blk_norm import fix_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int MAX_SHIFT = WIDTH-1,
  parameter int SHIFT_W   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  fix_blk_norm_if.slave io_bus
);

  localparam int                 CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(FRAME_LEN-1);
  localparam logic [SHIFT_W-1:0] MIN_INIT  = SHIFT_W'(WIDTH-1);
  localparam logic [SHIFT_W-1:0] SHIFT_CAP = SHIFT_W'(MAX_SHIFT);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_armed;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [WIDTH-1:0]   r_buf [FRAME_LEN];
  logic [SHIFT_W-1:0] r_min;
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] r_frame_exp;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_out_last;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_xfer;
  logic               w_fill_done;
  logic               w_drain_done;
  logic [CNT_W-1:0]   w_rd_next;
  logic [SHIFT_W-1:0] w_h;
  logic [SHIFT_W-1:0] w_min_new;
  logic [SHIFT_W-1:0] w_shift_new;

  fix_sign_cnt #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_sign_cnt (
    .i_data (io_bus.in_data),
    .o_cnt  (w_h)
  );

  assign w_accept     = io_bus.in_valid & w_in_ready;
  assign w_xfer       = r_out_valid & io_bus.out_ready;
  assign w_fill_done  = w_accept && (r_wr_cnt == LAST_IDX);
  assign w_drain_done = w_xfer && (r_rd_cnt == LAST_IDX);
  assign w_rd_next    = r_rd_cnt + CNT_W'(1);
  assign w_min_new    = (w_h < r_min) ? w_h : r_min;
  assign w_shift_new  = (w_min_new > SHIFT_CAP) ? SHIFT_CAP : w_min_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL:    if (w_fill_done)  w_next_state = DRAIN;
      DRAIN:   if (w_drain_done) w_next_state = FILL;
      default: w_next_state = FILL;
    endcase
  end

  // r_armed keeps in_ready low for the first cycle out of reset.
  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == FILL) w_in_ready = r_armed;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_cnt] <= io_bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_min       <= MIN_INIT;
      r_shift     <= '0;
      r_frame_exp <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        if (w_fill_done) begin
          r_min       <= MIN_INIT;
          r_shift     <= w_shift_new;
          r_frame_exp <= w_shift_new;
          r_rd_cnt    <= '0;
          r_out_data  <= r_buf[0];
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
        end else begin
          r_min <= w_min_new;
        end
      end
      // Each transfer preloads the next buffered sample so the output stays registered.
      if (w_xfer) begin
        if (w_drain_done) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_rd_cnt    <= '0;
        end else begin
          r_rd_cnt   <= w_rd_next;
          r_out_data <= r_buf[w_rd_next];
          r_out_last <= (w_rd_next == LAST_IDX);
        end
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_shift = r_shift;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.frame_exp = r_frame_exp;

endmodule

// File: tb/tb_fix_blk_norm.sv
// Frame-level scoreboard bench for fix_blk_norm (full clamp and MAX_SHIFT=8) plus fix_sign_cnt.
module tb_fix_blk_norm;
  import fix_pkg::*;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] exp;
    logic          last;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [W-1:0]  frameBuf [N];
  logic [W-1:0]  fillQ [$];
  expT           expQ [$];
  logic [SW-1:0] heldExp;
  int            sinceReset;
  logic [W-1:0]  cntIn;
  logic [SW-1:0] cntOut;
  logic [W-1:0]  pinIn [8];
  logic [SW-1:0] pinExp [8];

  fix_blk_norm_if #(.WIDTH(W), .SHIFT_W(SW)) bus ();
  fix_blk_norm_if #(.WIDTH(W), .SHIFT_W(SW)) bus8 ();

  fix_blk_norm #(.WIDTH(W), .FRAME_LEN(N), .MAX_SHIFT(W-1), .SHIFT_W(SW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  fix_blk_norm #(.WIDTH(W), .FRAME_LEN(N), .MAX_SHIFT(8), .SHIFT_W(SW)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus8)
  );

  fix_sign_cnt #(.WIDTH(W), .SHIFT_W(SW)) uCnt (
    .i_data (cntIn),
    .o_cnt  (cntOut)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [SW-1:0] cap8(input logic [SW-1:0] x);
    return (x > 4'd8) ? 4'd8 : x;
  endfunction

  task automatic setIn(input logic v, input logic [W-1:0] d);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus8.in_valid = v;
    bus8.in_data  = d;
  endtask

  task automatic setReady(input logic r);
    bus.out_ready  = r;
    bus8.out_ready = r;
  endtask

  // Offers frameBuf[0..count-1] in order with random in_valid gaps.
  task automatic applyStimulus(input int count, input int validPct);
    int   sent = 0;
    int   budget = 0;
    logic v;
    logic acc;
    while (sent < count && budget < 4000) begin
      v = ($urandom_range(99) < validPct);
      setIn(v, v ? frameBuf[sent] : W'($urandom));
      @(negedge clk);
      acc = v && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      budget++;
    end
    setIn(1'b0, '0);
    checkOutput("fillCount", sent, count);
  endtask

  // Pulls N samples with random out_ready, optionally stalling on one index and offering X input.
  task automatic drainFrame(input int readyPct, input int stallAt, input int stallLen, input bit xDrive);
    int   got = 0;
    int   budget = 0;
    int   stalled = 0;
    logic r;
    if (xDrive) setIn(1'b1, 'x);
    while (got < N && budget < 4000) begin
      if (got == stallAt && stalled < stallLen) begin
        r = 1'b0;
        stalled++;
      end else begin
        r = ($urandom_range(99) < readyPct);
      end
      setReady(r);
      @(negedge clk);
      if (r && bus.out_valid) got++;
      @(posedge clk); #1;
      budget++;
    end
    setIn(1'b0, '0);
    setReady(1'b0);
    checkOutput("drainCount", got, N);
  endtask

  // Scoreboard: frames complete at the Nth accepted sample and are replayed in order.
  always @(negedge clk) begin
    expT           e;
    logic [SW-1:0] m;
    if (rst) begin
      fillQ.delete();
      expQ.delete();
      heldExp    = '0;
      sinceReset = 0;
      checkOutput("rstOutValid", bus.out_valid, 1'b0);
      checkOutput("rstOutLast", bus.out_last, 1'b0);
      checkOutput("rstOutData", bus.out_data, '0);
      checkOutput("rstOutShift", bus.out_shift, '0);
      checkOutput("rstFrameExp", bus.frame_exp, '0);
      checkOutput("rstInReady", bus.in_ready, 1'b0);
      checkOutput("rstOutValid8", bus8.out_valid, 1'b0);
    end else begin
      checkOutput("inReady", bus.in_ready, (expQ.size() == 0) && (sinceReset > 0));
      checkOutput("outValid", bus.out_valid, expQ.size() != 0);
      checkOutput("outValid8", bus8.out_valid, expQ.size() != 0);
      checkOutput("frameExp", bus.frame_exp, heldExp);
      checkOutput("frameExp8", bus8.frame_exp, cap8(heldExp));
      if (expQ.size() != 0) begin
        e = expQ[0];
        checkOutput("outData", bus.out_data, e.data);
        checkOutput("outShift", bus.out_shift, e.exp);
        checkOutput("outLast", bus.out_last, e.last);
        checkOutput("outData8", bus8.out_data, e.data);
        checkOutput("outShift8", bus8.out_shift, cap8(e.exp));
        checkOutput("outLast8", bus8.out_last, e.last);
        if (bus.out_ready) void'(expQ.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        fillQ.push_back(bus.in_data);
        if (fillQ.size() == N) begin
          m = SW'(W-1);
          foreach (fillQ[i]) if (headroom(fillQ[i]) < m) m = headroom(fillQ[i]);
          foreach (fillQ[i]) expQ.push_back('{data: fillQ[i], exp: m, last: (i == N-1)});
          heldExp = m;
          fillQ.delete();
        end
      end
      sinceReset++;
    end
  end

  initial begin
    logic [W-1:0] tmp;
    rst = 1'b1;
    setIn(1'b0, '0);
    setReady(1'b0);
    cntIn = '0;

    pinIn  = '{16'h0000, 16'hFFFF, 16'h4000, 16'h8000, 16'h0001, 16'hFFFE, 16'h0010, 16'h0100};
    pinExp = '{4'd15,    4'd15,    4'd0,     4'd0,     4'd14,    4'd14,    4'd10,    4'd6};
    for (int i = 0; i < 8; i++) begin
      cntIn = pinIn[i];
      #1;
      checkOutput("signCntPin", cntOut, pinExp[i]);
      checkOutput("pkgHeadroomPin", headroom(pinIn[i]), pinExp[i]);
    end
    for (int i = 0; i < 200; i++) begin
      tmp   = W'($urandom);
      cntIn = W'($signed(tmp) >>> $urandom_range(15));
      #1;
      checkOutput("signCntRand", cntOut, headroom(cntIn));
    end

    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] reset released");
    @(negedge clk);
    checkOutput("inReadyFirstCycle", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("inReadyArmed", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Ramp 1..16: 0x0010 limits the frame to 10 redundant sign bits.
    for (int i = 0; i < N; i++) frameBuf[i] = W'(i + 1);
    applyStimulus(N, 100);
    @(negedge clk);
    checkOutput("rampFirstValid", bus.out_valid, 1'b1);
    checkOutput("rampFirstData", bus.out_data, 16'h0001);
    checkOutput("rampShift", bus.out_shift, 4'd10);
    @(posedge clk); #1;
    drainFrame(100, -1, 0, 1'b0);
    checkOutput("rampFrameExp", bus.frame_exp, 4'd10);
    checkOutput("rampFrameExp8", bus8.frame_exp, 4'd8);

    for (int i = 0; i < N; i++) frameBuf[i] = 16'h0001;
    frameBuf[5] = 16'h8000;
    applyStimulus(N, 100);
    drainFrame(100, -1, 0, 1'b0);
    checkOutput("minNegFrameExp", bus.frame_exp, 4'd0);
    checkOutput("minNegFrameExp8", bus8.frame_exp, 4'd0);

    for (int i = 0; i < N; i++) frameBuf[i] = 16'h0000;
    applyStimulus(N, 100);
    drainFrame(100, -1, 0, 1'b0);
    checkOutput("zeroFrameExp", bus.frame_exp, 4'd15);
    checkOutput("zeroFrameExp8", bus8.frame_exp, 4'd8);

    for (int i = 0; i < N; i++) frameBuf[i] = 16'hFFFF;
    applyStimulus(N, 100);
    drainFrame(100, -1, 0, 1'b0);
    checkOutput("onesFrameExp", bus.frame_exp, 4'd15);
    checkOutput("onesFrameExp8", bus8.frame_exp, 4'd8);

    // Stall five cycles on the third output while X samples are offered upstream.
    for (int i = 0; i < N; i++) frameBuf[i] = W'(16'h1230 + i);
    applyStimulus(N, 60);
    drainFrame(100, 2, 5, 1'b1);
    checkOutput("stallFrameExp", bus.frame_exp, 4'd2);

    for (int i = 0; i < N; i++) frameBuf[i] = 16'h7ABC;
    applyStimulus(7, 100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) frameBuf[i] = 16'h0100;
    applyStimulus(N, 100);
    drainFrame(100, -1, 0, 1'b0);
    checkOutput("postRstFrameExp", bus.frame_exp, 4'd6);
    checkOutput("postRstFrameExp8", bus8.frame_exp, 4'd6);

    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < N; i++) begin
        tmp         = W'($urandom);
        frameBuf[i] = W'($signed(tmp) >>> $urandom_range(15));
      end
      applyStimulus(N, 70);
      drainFrame(70, -1, 0, 1'b0);
    end

    checkOutput("pendingOutputs", expQ.size(), 0);
    checkOutput("pendingInputs", fillQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
